// File: rtl/mem_fill_ctrl.sv
// Cache refill / write-through controller in front of a single-port backing RAM.
// Serves one D-cache write, D-cache refill or I-cache refill at a time; every output is registered.
module mem_fill_ctrl #(
    parameter int READ_LATENCY  = 2,
    parameter int RAM_ADDR_BITS = 18
) (
    input  logic                     CLK_cpu,
    input  logic                     reset,
    input  logic                     icache_miss,
    input  logic [31:0]              icache_miss_addr,
    input  logic                     dcache_miss,
    input  logic [31:0]              dcache_miss_addr,
    input  logic                     dcache_wt_en,
    input  logic [31:0]              dcache_wt_addr,
    input  logic [31:0]              dcache_wt_data,
    input  logic [1:0]               dcache_wt_size,
    output logic                     busy,
    output logic                     icache_fetch,
    output logic [31:0]              icache_write_addr,
    output logic [31:0]              icache_write_data,
    output logic                     dcache_fetch,
    output logic [31:0]              dcache_write_addr,
    output logic [31:0]              dcache_write_data,
    output logic                     dcache_wt_ack,
    output logic [RAM_ADDR_BITS-1:0] ram_addr,
    output logic                     ram_re,
    output logic                     ram_we,
    output logic [3:0]               ram_wmask,
    output logic [31:0]              ram_wdata,
    input  logic [31:0]              ram_rdata
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WRITE   = 3'd1,
        READ    = 3'd2,
        WAIT    = 3'd3,
        RESPOND = 3'd4
    } state_t;

    localparam logic [2:0] LAT_LAST = 3'(READ_LATENCY - 1);

    state_t      state_r;
    logic        req_icache_r;
    logic [31:0] addr_r;
    logic        in_range_r;
    logic [2:0]  wait_cnt_r;

    logic [31:0] rd_addr_s;
    logic        rd_in_range_s;
    logic        wt_in_range_s;
    logic [31:0] rsp_data_s;
    logic [31:0] rsp_addr_s;

    // Byte lanes touched by a write of the given size at the given byte offset.
    function automatic logic [3:0] wmask_f(input logic [1:0] size, input logic [1:0] lo);
        logic [3:0] m;
        case (size)
            2'b00:   m = 4'b0001 << lo;
            2'b01:   m = lo[1] ? 4'b1100 : 4'b0011;
            2'b10:   m = 4'b1111;
            default: m = 4'b0000;
        endcase
        return m;
    endfunction

    // Write data replicated across lanes so the mask alone selects the target bytes.
    function automatic logic [31:0] wdata_f(input logic [1:0] size, input logic [31:0] d);
        logic [31:0] w;
        case (size)
            2'b00:   w = {4{d[7:0]}};
            2'b01:   w = {2{d[15:0]}};
            default: w = d;
        endcase
        return w;
    endfunction

    // D-cache refill outranks I-cache refill; addresses above 1MB never reach the RAM.
    always_comb begin
        rd_addr_s     = dcache_miss ? dcache_miss_addr : icache_miss_addr;
        rd_in_range_s = (rd_addr_s[31:20] == 12'h000);
        wt_in_range_s = (dcache_wt_addr[31:20] == 12'h000);
        rsp_data_s    = in_range_r ? ram_rdata : 32'h0000_0000;
        rsp_addr_s    = addr_r & 32'hFFFF_FFFC;
    end

    // Transaction FSM; strobes default low each cycle and pulse for exactly one cycle.
    always_ff @(posedge CLK_cpu or posedge reset) begin
        if (reset) begin
            state_r           <= IDLE;
            req_icache_r      <= 1'b0;
            addr_r            <= 32'h0000_0000;
            in_range_r        <= 1'b0;
            wait_cnt_r        <= 3'd0;
            busy              <= 1'b0;
            icache_fetch      <= 1'b0;
            icache_write_addr <= 32'h0000_0000;
            icache_write_data <= 32'h0000_0000;
            dcache_fetch      <= 1'b0;
            dcache_write_addr <= 32'h0000_0000;
            dcache_write_data <= 32'h0000_0000;
            dcache_wt_ack     <= 1'b0;
            ram_addr          <= '0;
            ram_re            <= 1'b0;
            ram_we            <= 1'b0;
            ram_wmask         <= 4'b0000;
            ram_wdata         <= 32'h0000_0000;
        end else begin
            ram_re        <= 1'b0;
            ram_we        <= 1'b0;
            dcache_wt_ack <= 1'b0;
            icache_fetch  <= 1'b0;
            dcache_fetch  <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (dcache_wt_en) begin
                        state_r       <= WRITE;
                        busy          <= 1'b1;
                        dcache_wt_ack <= 1'b1;
                        ram_we        <= wt_in_range_s && (dcache_wt_size != 2'b11);
                        ram_addr      <= dcache_wt_addr[RAM_ADDR_BITS+1:2];
                        ram_wmask     <= wmask_f(dcache_wt_size, dcache_wt_addr[1:0]);
                        ram_wdata     <= wdata_f(dcache_wt_size, dcache_wt_data);
                    end else if (dcache_miss || icache_miss) begin
                        state_r      <= READ;
                        busy         <= 1'b1;
                        req_icache_r <= !dcache_miss;
                        addr_r       <= rd_addr_s;
                        in_range_r   <= rd_in_range_s;
                        ram_re       <= rd_in_range_s;
                        ram_addr     <= rd_addr_s[RAM_ADDR_BITS+1:2];
                    end else begin
                        state_r <= IDLE;
                        busy    <= 1'b0;
                    end
                end
                WRITE: begin
                    state_r <= IDLE;
                    busy    <= 1'b0;
                end
                READ: begin
                    state_r    <= WAIT;
                    wait_cnt_r <= 3'd0;
                end
                WAIT: begin
                    if (wait_cnt_r == LAT_LAST) begin
                        state_r <= RESPOND;
                        if (req_icache_r) begin
                            icache_fetch      <= 1'b1;
                            icache_write_addr <= rsp_addr_s;
                            icache_write_data <= rsp_data_s;
                        end else begin
                            dcache_fetch      <= 1'b1;
                            dcache_write_addr <= rsp_addr_s;
                            dcache_write_data <= rsp_data_s;
                        end
                    end else begin
                        wait_cnt_r <= wait_cnt_r + 3'd1;
                    end
                end
                // No request sampling here: the requester uses the fetch cycle to drop its miss.
                RESPOND: begin
                    state_r <= IDLE;
                    busy    <= 1'b0;
                end
                default: begin
                    state_r <= IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_fill_ctrl.sv
// Randomized self-checking bench for mem_fill_ctrl: a per-batch schedule model predicts every
// strobe cycle and a byte-lane memory model predicts refill data.
module tb_mem_fill_ctrl;
    localparam int L  = 2;
    localparam int AB = 18;

    logic          CLK_cpu = 1'b0;
    logic          reset = 1'b1;
    logic          icache_miss = 1'b0, dcache_miss = 1'b0, dcache_wt_en = 1'b0;
    logic [31:0]   icache_miss_addr = '0, dcache_miss_addr = '0, dcache_wt_addr = '0, dcache_wt_data = '0;
    logic [1:0]    dcache_wt_size = 2'b10;
    logic          busy, icache_fetch, dcache_fetch, dcache_wt_ack, ram_re, ram_we;
    logic [31:0]   icache_write_addr, icache_write_data, dcache_write_addr, dcache_write_data;
    logic [AB-1:0] ram_addr;
    logic [3:0]    ram_wmask;
    logic [31:0]   ram_wdata, ram_rdata;

    int n_checks = 0;
    int n_errors = 0;

    mem_fill_ctrl #(.READ_LATENCY(L), .RAM_ADDR_BITS(AB)) dut (
        .CLK_cpu(CLK_cpu), .reset(reset),
        .icache_miss(icache_miss), .icache_miss_addr(icache_miss_addr),
        .dcache_miss(dcache_miss), .dcache_miss_addr(dcache_miss_addr),
        .dcache_wt_en(dcache_wt_en), .dcache_wt_addr(dcache_wt_addr),
        .dcache_wt_data(dcache_wt_data), .dcache_wt_size(dcache_wt_size),
        .busy(busy), .icache_fetch(icache_fetch), .icache_write_addr(icache_write_addr),
        .icache_write_data(icache_write_data), .dcache_fetch(dcache_fetch),
        .dcache_write_addr(dcache_write_addr), .dcache_write_data(dcache_write_data),
        .dcache_wt_ack(dcache_wt_ack), .ram_addr(ram_addr), .ram_re(ram_re), .ram_we(ram_we),
        .ram_wmask(ram_wmask), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    always #5 CLK_cpu = ~CLK_cpu;

    // Power-up content of every RAM word, so untouched words still carry distinct data.
    function automatic logic [31:0] seed_f(input int a);
        return (32'(a) * 32'h9E37_79B9) ^ 32'h5A5A_0F0F;
    endfunction

    // Backing RAM: stores content XOR seed, read pipeline of L cycles, garbage when not reading.
    bit   [31:0] ram_mem [0:(1<<AB)-1];
    logic [31:0] pipe [0:L-1];
    logic [31:0] ram_seed;
    assign ram_seed  = seed_f(int'(ram_addr));
    assign ram_rdata = pipe[L-1];
    always @(posedge CLK_cpu) begin
        pipe[0] <= ram_re ? (ram_mem[ram_addr] ^ ram_seed) : 32'hBAD0_BAD0;
        for (int i = 1; i < L; i++) pipe[i] <= pipe[i-1];
        if (ram_we)
            for (int b = 0; b < 4; b++)
                if (ram_wmask[b]) ram_mem[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8] ^ ram_seed[8*b +: 8];
    end

    // Reference memory: only words written so far are stored.
    logic [31:0] mm [int];
    function automatic logic [31:0] model_rd(input int a);
        return mm.exists(a) ? mm[a] : seed_f(a);
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One batch: raise the chosen requests together, predict every strobe per cycle, check all cycles.
    task automatic run_batch(input bit wt, input logic [31:0] wa, input logic [31:0] wd, input logic [1:0] ws,
                             input bit dm, input logic [31:0] da, input bit im, input logic [31:0] ia,
                             input int first);
        bit e_we[64], e_ack[64], e_re[64], e_if[64], e_df[64], e_busy[64];
        int t = first;
        int c_wr = -1, c_dre = -1, c_dfe = -1, c_ire = -1, c_ife = -1;
        logic [31:0] exp_d = '0, exp_i = '0, exp_mask = '0, exp_wdata = '0;
        for (int k = 0; k < 64; k++) begin
            e_we[k] = 0; e_ack[k] = 0; e_re[k] = 0; e_if[k] = 0; e_df[k] = 0; e_busy[k] = 0;
        end
        if (wt) begin
            int a = int'(wa[19:2]);
            logic [31:0] w = model_rd(a);
            c_wr = t; e_ack[t] = 1; e_busy[t] = 1;
            e_we[t] = (ws != 2'b11) && (wa[31:20] == 12'h000);
            exp_wdata = (ws == 2'b00) ? {4{wd[7:0]}} : (ws == 2'b01) ? {2{wd[15:0]}} : wd;
            for (int b = 0; b < 4; b++) begin
                bit hit = (ws == 2'b00) ? (b == int'(wa[1:0])) : (ws == 2'b01) ? ((b / 2) == int'(wa[1])) : 1'b1;
                if (hit) begin
                    exp_mask[b] = 1'b1;
                    w[8*b +: 8] = (ws == 2'b00) ? wd[7:0] : (ws == 2'b01) ? wd[8*(b%2) +: 8] : wd[8*b +: 8];
                end
            end
            if (e_we[t]) mm[a] = w;
            t += 2;
        end
        if (dm) begin
            for (int k = t; k <= t + 1 + L; k++) e_busy[k] = 1;
            e_re[t] = (da[31:20] == 12'h000);
            c_dre = t; c_dfe = t + 1 + L; e_df[c_dfe] = 1;
            exp_d = e_re[t] ? model_rd(int'(da[19:2])) : 32'h0;
            t += 3 + L;
        end
        if (im) begin
            for (int k = t; k <= t + 1 + L; k++) e_busy[k] = 1;
            e_re[t] = (ia[31:20] == 12'h000);
            c_ire = t; c_ife = t + 1 + L; e_if[c_ife] = 1;
            exp_i = e_re[t] ? model_rd(int'(ia[19:2])) : 32'h0;
            t += 3 + L;
        end
        @(posedge CLK_cpu); #1;
        dcache_wt_en = wt; dcache_wt_addr = wa; dcache_wt_data = wd; dcache_wt_size = ws;
        dcache_miss = dm; dcache_miss_addr = da; icache_miss = im; icache_miss_addr = ia;
        for (int k = 0; k < t + 2; k++) begin
            @(negedge CLK_cpu);
            check_eq($sformatf("busy@%0d", k), 32'(busy), 32'(e_busy[k]));
            check_eq($sformatf("ram_we@%0d", k), 32'(ram_we), 32'(e_we[k]));
            check_eq($sformatf("wt_ack@%0d", k), 32'(dcache_wt_ack), 32'(e_ack[k]));
            check_eq($sformatf("ram_re@%0d", k), 32'(ram_re), 32'(e_re[k]));
            check_eq($sformatf("ifetch@%0d", k), 32'(icache_fetch), 32'(e_if[k]));
            check_eq($sformatf("dfetch@%0d", k), 32'(dcache_fetch), 32'(e_df[k]));
            if (k == c_wr) begin
                check_eq("wr_addr", 32'(ram_addr), 32'(wa[19:2]));
                if (e_we[k]) begin
                    check_eq("wr_mask", 32'(ram_wmask), exp_mask);
                    check_eq("wr_data", ram_wdata, exp_wdata);
                end
            end
            if (k == c_dre && e_re[k]) check_eq("d_rd_addr", 32'(ram_addr), 32'(da[19:2]));
            if (k == c_ire && e_re[k]) check_eq("i_rd_addr", 32'(ram_addr), 32'(ia[19:2]));
            if (k == c_dfe) begin
                check_eq("d_fill_addr", dcache_write_addr, {da[31:2], 2'b00});
                check_eq("d_fill_data", dcache_write_data, exp_d);
            end
            if (k == c_ife) begin
                check_eq("i_fill_addr", icache_write_addr, {ia[31:2], 2'b00});
                check_eq("i_fill_data", icache_write_data, exp_i);
            end
            if (dcache_wt_ack) dcache_wt_en = 1'b0;
            if (dcache_fetch) dcache_miss = 1'b0;
            if (icache_fetch) icache_miss = 1'b0;
        end
        dcache_wt_en = 1'b0; dcache_miss = 1'b0; icache_miss = 1'b0;
    endtask

    function automatic logic [31:0] rand_addr();
        logic [31:0] a = 32'($urandom_range(0, 255));
        int sel = $urandom_range(0, 7);
        if (sel == 0) a = a | (32'h0010_0000 << $urandom_range(0, 11));
        else if (sel == 1) a = a | 32'h000F_FF00;
        return a;
    endfunction

    initial begin
        repeat (3) @(posedge CLK_cpu);
        @(negedge CLK_cpu);
        check_eq("rst_busy", 32'(busy), 32'h0);
        check_eq("rst_ram_re", 32'(ram_re), 32'h0);
        check_eq("rst_ram_addr", 32'(ram_addr), 32'h0);
        reset = 1'b0;

        run_batch(1, 32'h0000_0104, 32'hDEAD_BEEF, 2'b10, 0, '0, 0, '0, 1);
        run_batch(0, '0, '0, 2'b10, 0, '0, 1, 32'h0000_0104, 1);
        check_eq("directed_ifill", icache_write_data, 32'hDEAD_BEEF);
        run_batch(1, 32'h0000_0040, 32'h1111_2222, 2'b10, 1, 32'h0000_0040, 1, 32'h0000_0104, 1);
        run_batch(1, 32'h0000_0013, 32'h0000_00AB, 2'b00, 0, '0, 0, '0, 1);
        run_batch(1, 32'h0000_0016, 32'h0000_1234, 2'b01, 0, '0, 1, 32'h0000_0014, 1);
        run_batch(0, '0, '0, 2'b10, 1, 32'hF000_0010, 0, '0, 1);
        run_batch(1, 32'h0000_0020, 32'h5555_AAAA, 2'b11, 1, 32'h0000_0020, 0, '0, 1);
        run_batch(1, 32'h0100_0020, 32'h5555_AAAA, 2'b10, 0, '0, 0, '0, 1);
        run_batch(0, '0, '0, 2'b10, 0, '0, 0, '0, 1);

        // Reset while the read is waiting on the RAM: outputs clear at once and no fetch follows.
        @(negedge CLK_cpu);
        dcache_miss = 1'b1; dcache_miss_addr = 32'h0000_0040;
        @(posedge CLK_cpu);
        @(posedge CLK_cpu);
        #3 reset = 1'b1;
        #1;
        check_eq("async_busy", 32'(busy), 32'h0);
        check_eq("async_ram_addr", 32'(ram_addr), 32'h0);
        check_eq("async_dfetch", 32'(dcache_fetch), 32'h0);
        for (int k = 0; k < 4; k++) begin
            @(negedge CLK_cpu);
            check_eq("rst_no_fetch", 32'(dcache_fetch), 32'h0);
        end
        reset = 1'b0;
        run_batch(0, '0, '0, 2'b10, 1, 32'h0000_0040, 0, '0, 0);

        for (int n = 0; n < 60; n++) begin
            logic [31:0] wa = rand_addr();
            logic [31:0] da = $urandom_range(0, 3) == 0 ? wa : rand_addr();
            run_batch(1'($urandom_range(0, 1)), wa, $urandom, 2'($urandom_range(0, 3)),
                      1'($urandom_range(0, 1)), da, 1'($urandom_range(0, 1)), rand_addr(), 1);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/mem_fill_ctrl.md
MEM_FILL_CTRL -- requirements
Module: mem_fill_ctrl

Interface
REQ-001 SHALL have parameter READ_LATENCY, default 2, meaning the backing-RAM read latency in cycles (legal range 1..7).
REQ-002 SHALL have parameter RAM_ADDR_BITS, default 18, meaning the word-address width of the backing RAM (1MB user memory).
REQ-003 SHALL use one clock and an asynchronous active-high reset, with ports: CLK_cpu  in  1  clock; reset  in  1  asynchronous active-high reset.
REQ-004 SHALL have port: icache_miss  in  1  I-cache refill request, level, held until icache_fetch.
REQ-005 SHALL have port: icache_miss_addr  in  32  I-cache refill byte address.
REQ-006 SHALL have port: dcache_miss  in  1  D-cache refill request, level, held until dcache_fetch.
REQ-007 SHALL have port: dcache_miss_addr  in  32  D-cache refill byte address.
REQ-008 SHALL have ports for the D-cache write-through request: dcache_wt_en  in  1  request, level, held until dcache_wt_ack; dcache_wt_addr  in  32; dcache_wt_data  in  32; dcache_wt_size  in  2  (00 byte, 01 half, 10 word, 11 none).
REQ-009 SHALL have port: busy  out  1  high whenever the state is not IDLE.
REQ-010 SHALL have ports for the I-cache refill response: icache_fetch  out  1  one-cycle refill strobe; icache_write_addr  out  32; icache_write_data  out  32.
REQ-011 SHALL have ports for the D-cache refill response: dcache_fetch  out  1  one-cycle refill strobe; dcache_write_addr  out  32; dcache_write_data  out  32.
REQ-012 SHALL have port: dcache_wt_ack  out  1  one-cycle write-accept strobe.
REQ-013 SHALL have ports for the backing RAM: ram_addr  out  RAM_ADDR_BITS  word address; ram_re  out  1; ram_we  out  1; ram_wmask  out  4; ram_wdata  out  32; ram_rdata  in  32.

Function
REQ-014 SHALL implement the states IDLE, WRITE, READ, WAIT and RESPOND, and all outputs SHALL be registered.
REQ-015 SHALL sample requests only in IDLE, with fixed priority dcache_wt_en > dcache_miss > icache_miss; simultaneous requests SHALL be served one per transaction in that order.
REQ-016 SHALL, in IDLE with no request, remain in IDLE and drive all strobes low.
REQ-017 SHALL, when a write is accepted at edge N, drive ram_we=1, dcache_wt_ack=1 and ram_addr=wt_addr[RAM_ADDR_BITS+1:2] for the cycle after N, then return to IDLE at edge N+1.
REQ-018 SHALL compute the write mask as follows: byte = 4'b0001<<addr[1:0] with the data byte replicated to all lanes; half = addr[1] ? 1100 : 0011 with addr[0] ignored and the halfword replicated; word = 1111.
REQ-019 SHALL, for wt_size 11, acknowledge the write with ram_we=0.
REQ-020 SHALL, for a write with addr[31:20]≠0, acknowledge the write with ram_we=0.
REQ-021 SHALL, when a read is accepted at edge N, latch the requester and the address, drive ram_re=1 for exactly one cycle (edge N to N+1), then wait.
REQ-022 SHALL capture ram_rdata at edge N+1+READ_LATENCY, and the matching fetch SHALL be high for one cycle after that edge, with write_addr = {addr[31:2],2'b00} and write_data = the captured data.
REQ-023 SHALL return from RESPOND to IDLE at edge N+2+READ_LATENCY without sampling requests at that edge, so the requester has the fetch cycle to drop its miss line.
REQ-024 SHALL, for a read with addr[31:20]≠0, skip the RAM access (ram_re=0) and still fetch-respond with data 0 at the same latency.
REQ-025 SHALL hold every strobe low outside the states that assert it, and the other cache's fetch SHALL never be asserted.
REQ-026 SHALL hold ram_addr, ram_wdata and ram_wmask stable and ignore new requests while busy is high.

Reset
REQ-027 SHALL, on reset assertion (asynchronous, any state), immediately set the state to IDLE, set all outputs to 0, and abandon any in-flight read with no fetch strobe.
REQ-028 SHALL begin request sampling at the first rising edge after reset is released.

Verification
REQ-029 SHALL pass this directed scenario: READ_LATENCY=2, icache_miss with addr 0x00000104 sampled at edge 0, RAM returns 0xDEADBEEF -> ram_re=1 with ram_addr=0x41 during cycle 0-1; icache_fetch=1 during cycle 3-4 with addr 0x104 and data 0xDEADBEEF; busy low after edge 4.
REQ-030 SHALL pass this directed scenario: dcache_wt_en, dcache_miss and icache_miss all raised at edge 0 -> write acknowledged first, then dcache_fetch, then icache_fetch; no overlap between them.
REQ-031 SHALL pass this directed scenario: byte write of 0xAB to 0x00000013 -> ram_wmask=1000, ram_wdata=0xABABABAB, ram_addr=0x4; and halfword write of 0x1234 to 0x00000016 -> ram_wmask=1100, ram_wdata=0x12341234.
REQ-032 SHALL pass this directed scenario: dcache_miss with addr 0xF0000010 -> ram_re stays 0 and dcache_fetch is asserted at normal latency with data 0.
REQ-033 SHALL pass this directed scenario: reset asserted mid-WAIT -> outputs go to 0 without a clock edge, no fetch is produced, and a held miss is re-served from scratch after release.
